// File: rtl/pll_ctrl_seq_if.sv
// Normal-mode control bundle of the main PLL: host requests and configuration in,
// PLL control levels and sequencer status out.
interface pll_ctrl_seq_if;
    logic       i_start;
    logic       i_stop;
    logic [5:0] i_cfg_p;
    logic [9:0] i_cfg_m;
    logic [2:0] i_cfg_s;
    logic [1:0] i_cfg_icp;
    logic       i_cfg_bypass;
    logic       i_lock;
    logic [4:0] i_afc_code;
    logic [5:0] o_norm_p;
    logic [9:0] o_norm_m;
    logic [2:0] o_norm_s;
    logic [1:0] o_norm_icp;
    logic       o_norm_resetb;
    logic       o_norm_lock_en;
    logic       o_norm_bypass;
    logic       o_norm_fout_mask;
    logic       o_busy;
    logic       o_locked;
    logic       o_fail;
    logic       o_lock_lost;
    logic [4:0] o_afc_cap;
    logic [1:0] o_attempt;

    modport master (
        output i_start, i_stop, i_cfg_p, i_cfg_m, i_cfg_s, i_cfg_icp, i_cfg_bypass,
               i_lock, i_afc_code,
        input  o_norm_p, o_norm_m, o_norm_s, o_norm_icp, o_norm_resetb, o_norm_lock_en,
               o_norm_bypass, o_norm_fout_mask, o_busy, o_locked, o_fail, o_lock_lost,
               o_afc_cap, o_attempt
    );

    modport slave (
        input  i_start, i_stop, i_cfg_p, i_cfg_m, i_cfg_s, i_cfg_icp, i_cfg_bypass,
               i_lock, i_afc_code,
        output o_norm_p, o_norm_m, o_norm_s, o_norm_icp, o_norm_resetb, o_norm_lock_en,
               o_norm_bypass, o_norm_fout_mask, o_busy, o_locked, o_fail, o_lock_lost,
               o_afc_cap, o_attempt
    );
endinterface

// File: rtl/pll_ctrl_seq.sv
// Main PLL bring-up and lock supervision: resets the PLL, qualifies its lock output,
// retries on timeout, recovers from lock loss and reports status.
module pll_ctrl_seq #(
    parameter int RESET_CYC    = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 8,
    parameter int RETRY_MAX    = 3,
    parameter int CNT_W        = 16
) (
    input logic           i_clk,
    input logic           i_rst,
    pll_ctrl_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_WAIT_LOCK, S_LOCKED, S_FAIL, S_BYPASS
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] stab;
    logic             sync_1, lock_s;
    logic             in_lock_win, start_ok, accept, timeout, qual, last_try;
    logic             resetb_nxt, lock_en_nxt, bypass_nxt, mask_nxt;

    assign in_lock_win = (state == S_WAIT_LOCK) || (state == S_LOCKED);
    assign start_ok    = bus.i_start && (state inside {S_IDLE, S_LOCKED, S_FAIL, S_BYPASS});
    assign accept      = start_ok && !bus.i_stop;
    assign timeout     = (cnt == CNT_W'(LOCK_TIMEOUT - 1));
    assign qual        = (stab >= CNT_W'(LOCK_STABLE));
    assign last_try    = (bus.o_attempt == 2'(RETRY_MAX - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // A lock that qualifies on the timeout cycle wins over the timeout.
    always_comb begin
        state_nxt = state;
        if (bus.i_stop) begin
            state_nxt = S_IDLE;
        end else if (start_ok) begin
            state_nxt = bus.i_cfg_bypass ? S_BYPASS : S_RESET;
        end else begin
            case (state)
                S_RESET:     if (cnt == CNT_W'(RESET_CYC - 1)) state_nxt = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (qual)         state_nxt = S_LOCKED;
                    else if (timeout) state_nxt = last_try ? S_FAIL : S_RESET;
                end
                S_LOCKED:    if (!lock_s) state_nxt = S_RESET;
                default:     ;
            endcase
        end
    end

    // Control levels are decoded from the next state so they register with it.
    always_comb begin
        resetb_nxt  = 1'b0;
        lock_en_nxt = 1'b0;
        bypass_nxt  = 1'b0;
        mask_nxt    = 1'b1;
        case (state_nxt)
            S_WAIT_LOCK: begin resetb_nxt = 1'b1; lock_en_nxt = 1'b1; end
            S_LOCKED:    begin resetb_nxt = 1'b1; lock_en_nxt = 1'b1; mask_nxt = 1'b0; end
            S_BYPASS:    begin bypass_nxt = 1'b1; mask_nxt = 1'b0; end
            default:     ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_norm_resetb    <= 1'b0;
            bus.o_norm_lock_en   <= 1'b0;
            bus.o_norm_bypass    <= 1'b0;
            bus.o_norm_fout_mask <= 1'b1;
            bus.o_busy           <= 1'b0;
            bus.o_locked         <= 1'b0;
            bus.o_fail           <= 1'b0;
        end else begin
            bus.o_norm_resetb    <= resetb_nxt;
            bus.o_norm_lock_en   <= lock_en_nxt;
            bus.o_norm_bypass    <= bypass_nxt;
            bus.o_norm_fout_mask <= mask_nxt;
            bus.o_busy           <= (state_nxt == S_RESET) || (state_nxt == S_WAIT_LOCK);
            bus.o_locked         <= (state_nxt == S_LOCKED);
            bus.o_fail           <= (state_nxt == S_FAIL);
        end
    end

    // The synchronizer is flushed outside WAIT_LOCK/LOCKED so every attempt
    // qualifies lock only from samples taken with resetb released.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt    <= '0;
            stab   <= '0;
            sync_1 <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            if (state_nxt != state)
                cnt <= '0;
            else if (state == S_RESET || state == S_WAIT_LOCK)
                cnt <= cnt + CNT_W'(1);
            if (!in_lock_win) begin
                sync_1 <= 1'b0;
                lock_s <= 1'b0;
            end else begin
                sync_1 <= bus.i_lock;
                lock_s <= sync_1;
            end
            if (!in_lock_win || !lock_s) stab <= '0;
            else if (!qual)              stab <= stab + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_norm_p    <= '0;
            bus.o_norm_m    <= '0;
            bus.o_norm_s    <= '0;
            bus.o_norm_icp  <= '0;
            bus.o_lock_lost <= 1'b0;
            bus.o_attempt   <= '0;
            bus.o_afc_cap   <= '0;
        end else begin
            if (accept) begin
                bus.o_norm_p    <= bus.i_cfg_p;
                bus.o_norm_m    <= bus.i_cfg_m;
                bus.o_norm_s    <= bus.i_cfg_s;
                bus.o_norm_icp  <= bus.i_cfg_icp;
                bus.o_lock_lost <= 1'b0;
                bus.o_attempt   <= '0;
            end else if (state == S_LOCKED && state_nxt == S_RESET) begin
                bus.o_lock_lost <= 1'b1;
                bus.o_attempt   <= '0;
            end else if (state == S_WAIT_LOCK && state_nxt == S_RESET) begin
                bus.o_attempt   <= bus.o_attempt + 2'd1;
            end
            if (state_nxt == S_LOCKED && state != S_LOCKED)
                bus.o_afc_cap <= bus.i_afc_code;
        end
    end
endmodule

// File: doc/pll_ctrl_seq.md
Name: pll_ctrl_seq

Overview:
- Digital bring-up and lock-supervision sequencer for the main PLL's normal-mode control port.
- Latches a P/M/S/ICP configuration and drives the PLL resetb, lock_en, fout_mask and bypass controls.
- Qualifies the asynchronous PLL lock output, retries on timeout, recovers from lock loss and reports status.
- Its outputs connect directly to the PLL test-mux normal-mode inputs; o_lock and o_afc_code feed back from the PLL.

Parameters:
RESET_CYC, 16, cycles resetb is held low per reset attempt (>=2)
LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before an attempt fails (>=LOCK_STABLE+2)
LOCK_STABLE, 8, consecutive synchronized-lock-high cycles required to declare lock (>=1)
RETRY_MAX, 3, total lock attempts before FAIL (1..3)
CNT_W, 16, width of the shared cycle counter; must hold max(RESET_CYC, LOCK_TIMEOUT)

Ports:
i_clk  in  1  sole clock
i_rst  in  1  synchronous, active-high reset
i_start  in  1  one-cycle request: latch cfg and (re)start the sequence
i_stop  in  1  one-cycle request: return to IDLE
i_cfg_p  in  6  pre-divider
i_cfg_m  in  10  main divider
i_cfg_s  in  3  post-scaler
i_cfg_icp  in  2  charge-pump current
i_cfg_bypass  in  1  request bypass mode instead of lock
i_lock  in  1  PLL lock, asynchronous
i_afc_code  in  5  PLL AFC code
o_norm_p  out  6  latched P
o_norm_m  out  10  latched M
o_norm_s  out  3  latched S
o_norm_icp  out  2  latched ICP
o_norm_resetb  out  1  PLL reset, active low
o_norm_lock_en  out  1  PLL lock detector enable
o_norm_bypass  out  1  PLL bypass
o_norm_fout_mask  out  1  PLL output mask
o_busy  out  1  high in RESET or WAIT_LOCK
o_locked  out  1  high in LOCKED
o_fail  out  1  high in FAIL
o_lock_lost  out  1  sticky: lock dropped while LOCKED; cleared by i_start
o_afc_cap  out  5  AFC code captured on entry to LOCKED
o_attempt  out  2  lock attempt index of the current or last attempt (0-based)

Behaviour:
- All outputs are registered.
- Reset values: o_norm_resetb=0, o_norm_fout_mask=1, and all other outputs 0 (cfg outputs included). State is IDLE.
- i_lock passes through a 2-flop synchronizer to give lock_s, which adds 2 cycles of latency. A stable counter increments while lock_s=1 and clears when lock_s=0.
- States and output levels:
  - IDLE: resetb=0, mask=1, lock_en=0, bypass=0.
  - RESET: resetb=0, mask=1, lock_en=0.
  - WAIT_LOCK: resetb=1, lock_en=1, mask=1.
  - LOCKED: resetb=1, lock_en=1, mask=0.
  - FAIL: resetb=0, mask=1.
  - BYPASS: resetb=0, bypass=1, mask=0.
- i_start is accepted in IDLE, LOCKED, FAIL and BYPASS, and ignored in RESET and WAIT_LOCK. On acceptance:
  - Latch the cfg into o_norm_*.
  - Clear o_lock_lost and o_attempt.
  - Go to BYPASS if i_cfg_bypass=1, else to RESET.
- i_stop in any state goes to IDLE on the next edge and takes priority over a simultaneous i_start. The latched cfg, o_afc_cap and o_lock_lost are retained.
- RESET: lasts exactly RESET_CYC cycles, then goes to WAIT_LOCK. Counter and stable counter clear on entry.
- WAIT_LOCK:
  - Enter LOCKED on the edge after the stable counter reaches LOCK_STABLE.
  - Timeout is reached after LOCK_TIMEOUT cycles in the state.
  - If lock qualifies on the same cycle as the timeout, lock wins.
  - On timeout: if o_attempt==RETRY_MAX-1, go to FAIL; else increment o_attempt and go to RESET.
- LOCKED:
  - On entry, o_afc_cap captures i_afc_code.
  - A single lock_s=0 sample sets o_lock_lost, clears o_attempt and goes to RESET with the latched cfg.
- FAIL and BYPASS: held until i_start or i_stop.
- i_rst asserted mid-sequence forces the reset values on the next edge, with no partial-state carryover.
- o_norm_bypass=0 in every state except BYPASS. Going from BYPASS to RESET passes through resetb=0.

Test Plan:
- Param RESET_CYC=4, LOCK_TIMEOUT=32, LOCK_STABLE=3, RETRY_MAX=2. Pulse i_start with p=2, m=0x64, s=1 and hold i_lock=1 → resetb=0 for exactly 4 cycles, then resetb=1. o_locked rises 2+3+1 cycles after resetb rises. o_norm_m=0x64, mask falls with o_locked, and o_afc_cap equals i_afc_code (0x11).
- Hold i_lock=0 → two timeouts of 32 cycles each, o_attempt 0→1, then o_fail=1, resetb=0, mask=1. A second i_start clears o_attempt to 0.
- While LOCKED, drop i_lock for 1 cycle → o_lock_lost=1 after the 2-cycle sync, then a new RESET of 4 cycles and relock. o_lock_lost stays 1 until the next i_start.
- Toggle i_lock high 2 cycles / low 1 cycle repeatedly → never reaches LOCKED, and times out at 32 cycles per attempt.
- In WAIT_LOCK, assert i_start and i_stop together → IDLE, cfg unchanged. i_start alone in WAIT_LOCK → ignored.
- i_start with i_cfg_bypass=1 → BYPASS with o_norm_bypass=1, mask=0, o_busy=0. Assert i_rst mid-RESET → all outputs return to their reset values on the next edge.
